// File: rtl/fp_min_acc_pkg.sv
// fp_min_acc_pkg -- shared definitions for the FP running-minimum accumulator.
//   state_e     : accumulator FSM encoding (IDLE / ACC / DONE)
//   FP_MAXW     : widest FP format the compare helper accepts
//   fp_lt()     : sign-magnitude "a < b" for IEEE-style FP words
//   fp_exp_w()  : exponent field width for a given FP data width
package fp_min_acc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int FP_MAXW = 64;

   // Magnitudes are passed zero-extended so one function serves every DW.
   // Both zeros compare equal regardless of sign; otherwise a negative value
   // is below any positive one, and among negatives the larger magnitude wins.
   function automatic logic fp_lt(input logic               sa,
                                  input logic [FP_MAXW-2:0] ma,
                                  input logic               sb,
                                  input logic [FP_MAXW-2:0] mb);
      logic r;
      r = 1'b0;
      if ((ma == '0) && (mb == '0))
         r = 1'b0;
      else if (sa != sb)
         r = sa;
      else if (!sa)
         r = (ma < mb);
      else
         r = (ma > mb);
      return r;
   endfunction

   function automatic int fp_exp_w(input int dw);
      int w;
      w = 8;
      if (dw == 64)
         w = 11;
      else if (dw == 16)
         w = 5;
      return w;
   endfunction

endpackage

// File: rtl/fp_min_acc_if.sv
// fp_min_acc_if -- bus between the upstream min tree / system and fp_min_acc.
//   ena      : global advance enable (also clocks the upstream tree)
//   in_vld   : candidate batch presented to the tree inputs this cycle
//   in_last  : final batch of the query, qualified by in_vld
//   mi / md  : tree output index / minimum (LAT cycles behind in_vld)
//   hold     : out_vld & ~out_rdy; the system drops ena while it is high
//   out_vld / out_rdy / out_idx / out_dat : result handshake
// master = system/tree side, slave = accumulator side.
interface fp_min_acc_if #(
   parameter int DW = 32,
   parameter int IW = 3,
   parameter int BW = 8
);
   logic             ena;
   logic             in_vld;
   logic             in_last;
   logic [IW-1:0]    mi;
   logic [DW-1:0]    md;
   logic             hold;
   logic             out_vld;
   logic             out_rdy;
   logic [BW+IW-1:0] out_idx;
   logic [DW-1:0]    out_dat;

   modport master (
      output ena, in_vld, in_last, mi, md, out_rdy,
      input  hold, out_vld, out_idx, out_dat
   );

   modport slave (
      input  ena, in_vld, in_last, mi, md, out_rdy,
      output hold, out_vld, out_idx, out_dat
   );
endinterface

// File: rtl/fp_tag_dly.sv
// fp_tag_dly -- enable-gated tag delay line, DEPTH stages of WIDTH bits.
//   clk, rst : clock, asynchronous active-low reset (clears every stage)
//   en       : advance; all stages hold when low
//   d / q    : tag in / tag out DEPTH enabled cycles later
// Used to line up per-batch tags with the output of a pipelined tree that
// advances on the same enable. DEPTH must be at least 1.
module fp_tag_dly #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_q <= '0;
      end else if (en) begin
         pipe_q[0] <= d;
         for (int i = 1; i < DEPTH; i++)
            pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/fp_min_acc.sv
// fp_min_acc -- accumulates the global minimum (and its index) of a query
// made of several batches reduced by an upstream min tree of latency IW.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : fp_min_acc_if.slave (ena, in_vld, in_last, mi, md, hold,
//          out_vld, out_rdy, out_idx = {batch, mi}, out_dat)
// Optional build macro FP_MIN_ACC_NAN_SKIP_EN: NaN candidates never win and
// an all-NaN query reports the canonical quiet NaN.
module fp_min_acc
   import fp_min_acc_pkg::*;
#(
   parameter int DW = 32,
   parameter int IW = 3,
   parameter int BW = 8
) (
   input  logic clk,
   input  logic rst,
   fp_min_acc_if.slave bus
);

   localparam int LAT = IW;

   state_e              state_q, state_d;
   logic [BW-1:0]       batch_q, batch_d;
   logic [BW+IW-1:0]    idx_q, idx_d;
   logic [DW-1:0]       dat_q, dat_d;

   logic                a_vld, a_last, beat;
   logic                lt, win;
   logic [DW-1:0]       ld_dat;
   logic [FP_MAXW-2:0]  md_mag, best_mag;

   // Tags ride alongside the tree so they emerge together with mi/md.
   fp_tag_dly #(
      .DEPTH (LAT),
      .WIDTH (2)
   ) u_tag_dly (
      .clk (clk),
      .rst (rst),
      .en  (bus.ena),
      .d   ({bus.in_vld, bus.in_last}),
      .q   ({a_vld, a_last})
   );

   assign beat = a_vld & bus.ena;

   always_comb begin
      md_mag              = '0;
      md_mag[DW-2:0]      = bus.md[DW-2:0];
      best_mag            = '0;
      best_mag[DW-2:0]    = dat_q[DW-2:0];
      lt = fp_lt(bus.md[DW-1], md_mag, dat_q[DW-1], best_mag);
   end

`ifdef FP_MIN_ACC_NAN_SKIP_EN
   localparam int EW = fp_exp_w(DW);
   localparam int MW = DW - 1 - EW;
   localparam logic [DW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

   logic md_nan;
   logic nan_q, nan_d;

   assign md_nan = (&bus.md[DW-2 -: EW]) & (|bus.md[MW-1:0]);
   // A stored NaN loses to any real number; a NaN candidate never wins.
   assign win    = ~md_nan & (nan_q | lt);
   assign ld_dat = md_nan ? QNAN : bus.md;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         nan_q <= 1'b0;
      else
         nan_q <= nan_d;
   end

   always_comb begin
      nan_d = nan_q;
      if (beat) begin
         if (state_q == ST_IDLE)
            nan_d = md_nan;
         else if ((state_q == ST_ACC) && win)
            nan_d = 1'b0;
      end
   end
`else
   // Raw sign-magnitude ordering; NaN bit patterns sort like any other.
   assign win    = lt;
   assign ld_dat = bus.md;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         batch_q <= '0;
         idx_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         batch_q <= batch_d;
         idx_q   <= idx_d;
         dat_q   <= dat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      batch_d = batch_q;
      idx_d   = idx_q;
      dat_d   = dat_q;
      case (state_q)
         ST_IDLE: begin
            if (beat) begin
               state_d = a_last ? ST_DONE : ST_ACC;
               batch_d = '0;
               idx_d   = {{BW{1'b0}}, bus.mi};
               dat_d   = ld_dat;
            end
         end
         ST_ACC: begin
            if (beat) begin
               // Counter wraps silently; ties keep the earlier index.
               batch_d = batch_q + 1'b1;
               if (win) begin
                  idx_d = {batch_d, bus.mi};
                  dat_d = bus.md;
               end
               if (a_last)
                  state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Handshake completes independent of ena; stray beats are dropped.
            if (bus.out_rdy)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.out_vld = (state_q == ST_DONE);
   assign bus.out_idx = idx_q;
   assign bus.out_dat = dat_q;
   assign bus.hold    = bus.out_vld & ~bus.out_rdy;

endmodule
